// File: rtl/cache_pkg.sv
// Shared types and widths for the 2-way set-associative write-back cache controller.
package cache_pkg;

  localparam int unsigned SETS_DEF = 4;
  localparam int unsigned AW_DEF   = 8;
  localparam int unsigned DW_DEF   = 8;
  localparam int unsigned IDX_W    = $clog2(SETS_DEF);
  localparam int unsigned TAG_W    = AW_DEF - IDX_W;

  typedef enum logic [1:0] {IDLE, COMPARE, WRITEBACK, ALLOCATE} state_t;

  typedef struct packed {
    logic             valid;
    logic             dirty;
    logic [TAG_W-1:0] tag;
    logic [DW_DEF-1:0] data;
  } way_t;

endpackage

// File: rtl/cache_set_array.sv
// Two-way set storage with per-set LRU bit: tag-compare/victim read port and one write port.
module cache_set_array
  import cache_pkg::*;
#(
  parameter int unsigned SETS = SETS_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] idx,
  input  logic [TAG_W-1:0] rd_tag,
  output logic             hit_c,
  output logic             hit_way_c,
  output way_t             hit_entry_c,
  output logic             victim_way_c,
  output way_t             victim_entry_c,
  input  logic             wr_en,
  input  logic             wr_way,
  input  way_t             wr_entry,
  input  logic             lru_en,
  input  logic             lru_way
);

  way_t            ways [SETS][2];
  logic [SETS-1:0] lru;
  way_t            e0;
  logic            m0;
  logic            m1;
  way_t            e1;

  // lru[s] names the least recently used way of set s
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < int'(SETS); s++) begin
        ways[s][0] <= '0;
        ways[s][1] <= '0;
      end
      lru <= '0;
    end else begin
      if (wr_en) ways[idx][wr_way] <= wr_entry;
      if (lru_en) lru[idx] <= ~lru_way;
    end
  end

  always_comb begin
    e0             = ways[idx][0];
    e1             = ways[idx][1];
    m0             = e0.valid && (e0.tag == rd_tag);
    m1             = e1.valid && (e1.tag == rd_tag);
    hit_c          = m0 || m1;
    hit_way_c      = !m0;
    hit_entry_c    = m0 ? e0 : e1;
    victim_way_c   = !e0.valid ? 1'b0 : (!e1.valid ? 1'b1 : lru[idx]);
    victim_entry_c = victim_way_c ? e1 : e0;
  end

endmodule

// File: rtl/cache_controller.sv
// Lookup / writeback / allocate sequencer for a 2-way write-back, write-allocate cache.
// Optional CACHE_STATS_EN adds saturating 16-bit hit_count / miss_count outputs.
module cache_controller
  import cache_pkg::*;
#(
  parameter int unsigned SETS = SETS_DEF,
  parameter int unsigned AW   = AW_DEF,
  parameter int unsigned DW   = DW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_done,
  output logic [DW-1:0] cpu_rdata,
  output logic          hit,
  output logic          miss,
  output logic          dirty,
`ifdef CACHE_STATS_EN
  output logic [15:0]   hit_count,
  output logic [15:0]   miss_count,
`endif
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack
);

  localparam int unsigned IW = $clog2(SETS);

  state_t          state_q, state_d;
  logic            req_we_q, req_we_d;
  logic [AW-1:0]   req_addr_q, req_addr_d;
  logic [DW-1:0]   req_wdata_q, req_wdata_d;
  logic            replay_q, replay_d;
  logic            victim_q, victim_d;
  logic            cpu_done_d, hit_d, miss_d, dirty_d;
  logic [DW-1:0]   cpu_rdata_d;
  logic            mem_req_d, mem_we_d;
  logic [AW-1:0]   mem_addr_d;
  logic [DW-1:0]   mem_wdata_d;

  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] req_tag;
  logic             hit_c, hit_way_c, victim_way_c;
  way_t             hit_entry_c, victim_entry_c;
  logic             wr_en, wr_way, lru_en;
  way_t             wr_entry;

  assign idx     = IDX_W'(req_addr_q[IW-1:0]);
  assign req_tag = TAG_W'(req_addr_q[AW-1:IW]);

  cache_set_array #(.SETS(SETS)) u_array (
    .clk            (clk),
    .rst            (rst),
    .idx            (idx),
    .rd_tag         (req_tag),
    .hit_c          (hit_c),
    .hit_way_c      (hit_way_c),
    .hit_entry_c    (hit_entry_c),
    .victim_way_c   (victim_way_c),
    .victim_entry_c (victim_entry_c),
    .wr_en          (wr_en),
    .wr_way         (wr_way),
    .wr_entry       (wr_entry),
    .lru_en         (lru_en),
    .lru_way        (hit_way_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      req_we_q    <= 1'b0;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      replay_q    <= 1'b0;
      victim_q    <= 1'b0;
      cpu_done    <= 1'b0;
      cpu_rdata   <= '0;
      hit         <= 1'b0;
      miss        <= 1'b0;
      dirty       <= 1'b0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
    end else begin
      state_q     <= state_d;
      req_we_q    <= req_we_d;
      req_addr_q  <= req_addr_d;
      req_wdata_q <= req_wdata_d;
      replay_q    <= replay_d;
      victim_q    <= victim_d;
      cpu_done    <= cpu_done_d;
      cpu_rdata   <= cpu_rdata_d;
      hit         <= hit_d;
      miss        <= miss_d;
      dirty       <= dirty_d;
      mem_req     <= mem_req_d;
      mem_we      <= mem_we_d;
      mem_addr    <= mem_addr_d;
      mem_wdata   <= mem_wdata_d;
    end
  end

  // replay_q marks the post-fill lookup: it neither re-pulses miss nor counts as a hit
  always_comb begin
    state_d     = state_q;
    req_we_d    = req_we_q;
    req_addr_d  = req_addr_q;
    req_wdata_d = req_wdata_q;
    replay_d    = replay_q;
    victim_d    = victim_q;
    cpu_done_d  = 1'b0;
    cpu_rdata_d = cpu_rdata;
    hit_d       = 1'b0;
    miss_d      = 1'b0;
    dirty_d     = 1'b0;
    mem_req_d   = mem_req;
    mem_we_d    = mem_we;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    wr_en       = 1'b0;
    wr_way      = victim_q;
    wr_entry    = victim_entry_c;
    lru_en      = 1'b0;

    case (state_q)
      IDLE: begin
        if (cpu_req && !cpu_done) begin
          req_we_d    = cpu_we;
          req_addr_d  = cpu_addr;
          req_wdata_d = cpu_wdata;
          replay_d    = 1'b0;
          state_d     = COMPARE;
        end
      end
      COMPARE: begin
        if (hit_c) begin
          cpu_done_d = 1'b1;
          hit_d      = !replay_q;
          lru_en     = 1'b1;
          if (req_we_q) begin
            wr_en    = 1'b1;
            wr_way   = hit_way_c;
            wr_entry = '{valid: 1'b1, dirty: 1'b1, tag: req_tag, data: req_wdata_q};
          end else begin
            cpu_rdata_d = hit_entry_c.data;
          end
          state_d = IDLE;
        end else begin
          miss_d    = !replay_q;
          replay_d  = 1'b1;
          victim_d  = victim_way_c;
          mem_req_d = 1'b1;
          if (victim_entry_c.valid && victim_entry_c.dirty) begin
            dirty_d     = 1'b1;
            mem_we_d    = 1'b1;
            mem_addr_d  = AW'({victim_entry_c.tag, idx});
            mem_wdata_d = victim_entry_c.data;
            state_d     = WRITEBACK;
          end else begin
            mem_we_d   = 1'b0;
            mem_addr_d = req_addr_q;
            state_d    = ALLOCATE;
          end
        end
      end
      WRITEBACK: begin
        if (mem_req && mem_ack) begin
          wr_en          = 1'b1;
          wr_entry.dirty = 1'b0;
          mem_req_d      = 1'b0;
          mem_we_d       = 1'b0;
          state_d        = ALLOCATE;
        end
      end
      ALLOCATE: begin
        // one idle cycle after a writeback so each transfer is a distinct request
        if (!mem_req) begin
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = req_addr_q;
        end else if (mem_ack) begin
          wr_en     = 1'b1;
          wr_entry  = '{valid: 1'b1, dirty: 1'b0, tag: req_tag, data: mem_rdata};
          mem_req_d = 1'b0;
          state_d   = COMPARE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef CACHE_STATS_EN
  logic [15:0] hit_cnt_q, miss_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (hit && (hit_cnt_q != 16'hFFFF)) hit_cnt_q <= hit_cnt_q + 16'd1;
      if (miss && (miss_cnt_q != 16'hFFFF)) miss_cnt_q <= miss_cnt_q + 16'd1;
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
`endif

endmodule

// File: tb/tb_cache_controller.sv
// Directed scoreboard bench for cache_controller (SETS=4); stats checks when CACHE_STATS_EN is defined.
module tb_cache_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic       cpu_req, cpu_we;
  logic [7:0] cpu_addr, cpu_wdata;
  logic       cpu_done;
  logic [7:0] cpu_rdata;
  logic       hit, miss, dirty;
  logic       mem_req, mem_we;
  logic [7:0] mem_addr, mem_wdata;
  logic [7:0] mem_rdata;
  logic       mem_ack;
`ifdef CACHE_STATS_EN
  logic [15:0] hit_count, miss_count;
`endif

  cache_controller dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_done  (cpu_done),
    .cpu_rdata (cpu_rdata),
    .hit       (hit),
    .miss      (miss),
    .dirty     (dirty),
`ifdef CACHE_STATS_EN
    .hit_count (hit_count),
    .miss_count(miss_count),
`endif
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       we;
    logic [7:0] addr;
    logic [7:0] data;
  } mop_t;

  typedef struct {
    logic       hit;
    logic       miss;
    logic       dirty;
    logic [7:0] rdata;
  } cexp_t;

  mop_t  mexp_q[$];
  cexp_t cexp_q[$];

  int   n_checks = 0;
  int   n_errors = 0;
  logic [7:0] mem [256];
  int   ack_delay = 3;
  logic ack_hold  = 1'b0;
  int   req_cnt   = 0;
  logic prev_req  = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Memory model: ack in the ack_delay-th request cycle, or always when ack_hold
  always @(negedge clk) begin
    mop_t m;
    if (ack_hold && mem_req) check("mem_req_width", 32'(prev_req), 32'(1'b0));
    prev_req = mem_req;
    if (mem_req) req_cnt++;
    else req_cnt = 0;
    mem_ack   = ack_hold || (mem_req && (req_cnt >= ack_delay));
    mem_rdata = mem[mem_addr];
    if (mem_req && mem_ack && !rst) begin
      check("mem_unexpected", 32'(mexp_q.size() > 0), 32'(1'b1));
      if (mexp_q.size() > 0) begin
        m = mexp_q.pop_front();
        check("mem_op", {15'd0, mem_we, mem_addr, (mem_we ? mem_wdata : 8'h00)},
                        {15'd0, m.we, m.addr, (m.we ? m.data : 8'h00)});
      end
      if (mem_we) mem[mem_addr] = mem_wdata;
    end
  end

  task automatic init_mem();
    for (int i = 0; i < 256; i++) mem[i] = 8'(i + 8'h40);
    mem[8'h14] = 8'hA5;
  endtask

  task automatic push_mem(input logic we, input logic [7:0] addr, input logic [7:0] data);
    mexp_q.push_back('{we: we, addr: addr, data: data});
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    cpu_req = 1'b0;
    @(negedge clk);
    check("reset_outputs", {9'd0, cpu_done, cpu_rdata, hit, miss, dirty, mem_req, mem_we, mem_addr},
                           32'd0);
    rst = 1'b0;
    mexp_q.delete();
  endtask

  task automatic cpu_op(input logic we, input logic [7:0] addr, input logic [7:0] wd,
                        input logic exp_miss, input logic exp_dirty, input logic [7:0] exp_rd);
    cexp_t e;
    int    cyc;
    logic  got, saw_miss, saw_dirty, saw_both, hit_at_done;
    int    miss_pulses;
    cexp_q.push_back('{hit: !exp_miss, miss: exp_miss, dirty: exp_dirty, rdata: exp_rd});
    @(negedge clk);
    cpu_req   = 1'b1;
    cpu_we    = we;
    cpu_addr  = addr;
    cpu_wdata = wd;
    cyc = 0; got = 1'b0; saw_miss = 1'b0; saw_dirty = 1'b0; saw_both = 1'b0;
    hit_at_done = 1'b0; miss_pulses = 0;
    while (!got && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (miss) begin saw_miss = 1'b1; miss_pulses++; end
      if (dirty) saw_dirty = 1'b1;
      if (hit && miss) saw_both = 1'b1;
      if (cpu_done) begin got = 1'b1; hit_at_done = hit; end
    end
    cpu_req = 1'b0;
    e = cexp_q.pop_front();
    check("done_timeout", 32'(got), 32'(1'b1));
    check("hit", 32'(hit_at_done), 32'(e.hit));
    check("miss", 32'(saw_miss), 32'(e.miss));
    check("miss_pulses", 32'(miss_pulses), 32'(e.miss ? 1 : 0));
    check("dirty", 32'(saw_dirty), 32'(e.dirty));
    check("hit_and_miss", 32'(saw_both), 32'(1'b0));
    check("rdata", 32'(cpu_rdata), 32'(e.rdata));
    if (e.hit) check("hit_latency", 32'(cyc), 32'd2);
    check("mem_ops_pending", 32'(mexp_q.size()), 32'd0);
    mexp_q.delete();
  endtask

  // Fill, hit, dirty eviction and write-miss eviction on sets 0 and 1
  task automatic seq_a();
    init_mem();
    push_mem(1'b0, 8'h14, 8'h00);
    cpu_op(1'b0, 8'h14, 8'h00, 1'b1, 1'b0, 8'hA5);
    cpu_op(1'b0, 8'h14, 8'h00, 1'b0, 1'b0, 8'hA5);
    cpu_op(1'b1, 8'h14, 8'h3C, 1'b0, 1'b0, 8'hA5);
    push_mem(1'b0, 8'h04, 8'h00);
    cpu_op(1'b0, 8'h04, 8'h00, 1'b1, 1'b0, 8'h44);
    push_mem(1'b1, 8'h14, 8'h3C);
    push_mem(1'b0, 8'h24, 8'h00);
    cpu_op(1'b0, 8'h24, 8'h00, 1'b1, 1'b1, 8'h64);
    push_mem(1'b0, 8'h31, 8'h00);
    cpu_op(1'b1, 8'h31, 8'h77, 1'b1, 1'b0, 8'h64);
    push_mem(1'b0, 8'h01, 8'h00);
    cpu_op(1'b0, 8'h01, 8'h00, 1'b1, 1'b0, 8'h41);
    push_mem(1'b1, 8'h31, 8'h77);
    push_mem(1'b0, 8'h11, 8'h00);
    cpu_op(1'b0, 8'h11, 8'h00, 1'b1, 1'b1, 8'h51);
    cpu_op(1'b0, 8'h24, 8'h00, 1'b0, 1'b0, 8'h64);
    check("mem_14_written_back", 32'(mem[8'h14]), 32'h3C);
    check("mem_31_written_back", 32'(mem[8'h31]), 32'h77);
  endtask

  initial begin
    int waited;
    logic wb_seen;
    rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    init_mem();
    #1;
    check("async_reset_outputs", {9'd0, cpu_done, cpu_rdata, hit, miss, dirty, mem_req, mem_we, mem_addr},
                                 32'd0);

    do_reset();
    ack_delay = 3; ack_hold = 1'b0;
    seq_a();

    do_reset();
    ack_hold = 1'b1;
    seq_a();
    ack_hold = 1'b0;

    // Reset mid-writeback drops mem_req asynchronously and loses the transfer
    do_reset();
    ack_delay = 3;
    init_mem();
    push_mem(1'b0, 8'h14, 8'h00);
    cpu_op(1'b0, 8'h14, 8'h00, 1'b1, 1'b0, 8'hA5);
    cpu_op(1'b1, 8'h14, 8'h3C, 1'b0, 1'b0, 8'hA5);
    push_mem(1'b0, 8'h04, 8'h00);
    cpu_op(1'b0, 8'h04, 8'h00, 1'b1, 1'b0, 8'h44);
    ack_delay = 1000;
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h24;
    waited = 0; wb_seen = 1'b0;
    while (!wb_seen && waited < 20) begin
      @(negedge clk);
      waited++;
      if (mem_req && mem_we) wb_seen = 1'b1;
    end
    check("wb_started", {22'd0, wb_seen, mem_we, mem_addr}, {22'd0, 1'b1, 1'b1, 8'h14});
    #2 rst = 1'b1;
    #1;
    check("rst_in_wb_outputs", {9'd0, cpu_done, cpu_rdata, hit, miss, dirty, mem_req, mem_we, mem_addr},
                               32'd0);
    @(negedge clk);
    cpu_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    mexp_q.delete();
    ack_delay = 3;
    check("mem_14_untouched", 32'(mem[8'h14]), 32'hA5);
    push_mem(1'b0, 8'h14, 8'h00);
    cpu_op(1'b0, 8'h14, 8'h00, 1'b1, 1'b0, 8'hA5);

`ifdef CACHE_STATS_EN
    do_reset();
    check("stats_reset", {hit_count, miss_count}, 32'd0);
    init_mem();
    push_mem(1'b0, 8'h14, 8'h00);
    cpu_op(1'b0, 8'h14, 8'h00, 1'b1, 1'b0, 8'hA5);
    cpu_op(1'b0, 8'h14, 8'h00, 1'b0, 1'b0, 8'hA5);
    push_mem(1'b0, 8'h04, 8'h00);
    cpu_op(1'b0, 8'h04, 8'h00, 1'b1, 1'b0, 8'h44);
    cpu_op(1'b0, 8'h04, 8'h00, 1'b0, 1'b0, 8'h44);
    cpu_op(1'b0, 8'h14, 8'h00, 1'b0, 1'b0, 8'hA5);
    @(negedge clk);
    check("hit_count", 32'(hit_count), 32'd3);
    check("miss_count", 32'(miss_count), 32'd2);
    force dut.hit_cnt_q = 16'hFFFF;
    @(negedge clk);
    release dut.hit_cnt_q;
    cpu_op(1'b0, 8'h14, 8'h00, 1'b0, 1'b0, 8'hA5);
    @(negedge clk);
    check("hit_count_saturate", 32'(hit_count), 32'hFFFF);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/cache_controller.md
Name: cache_controller

Overview:
- Sequencing controller for the 8-bit memory hierarchy: a 2-way set-associative, write-back, write-allocate cache placed between one CPU-side requester and the backing memory.
- Holds tag, valid, dirty and LRU state plus one data byte per way.
- Runs the lookup, writeback and allocate sequence, then drives hit/miss/dirty status.

Parameters:
- SETS, 4, number of sets; power of 2, minimum 2; index = addr[$clog2(SETS)-1:0], tag = remaining upper address bits.
- AW, 8, address width.
- DW, 8, data width.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-high reset.
- cpu_req  in  1  request; held high until cpu_done.
- cpu_we  in  1  1 = write, 0 = read; stable while cpu_req is high.
- cpu_addr  in  AW  request address.
- cpu_wdata  in  DW  write data.
- cpu_done  out  1  one-cycle completion pulse.
- cpu_rdata  out  DW  read data; valid when cpu_done=1.
- hit  out  1  one-cycle pulse; request completed as a hit.
- miss  out  1  one-cycle pulse; first lookup of a request missed.
- dirty  out  1  one-cycle pulse; a dirty victim writeback is starting.
- mem_req  out  1  memory request.
- mem_we  out  1  memory write.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  memory read data; valid with mem_ack.
- mem_ack  in  1  memory completion; sampled while mem_req=1.

Behaviour:
- Reset (asynchronous, effective immediately): state IDLE; all valid, dirty and LRU bits cleared; all outputs 0. A reset during WRITEBACK or ALLOCATE drops mem_req in the same cycle and abandons the transfer.
- IDLE: on a rising edge with cpu_req=1 and cpu_done=0, latch we/addr/wdata and go to COMPARE. While cpu_done is high, cpu_req is ignored; the requester must drop cpu_req in that cycle.
- COMPARE, hit (valid way with tag match):
  - Read: cpu_rdata = way data.
  - Write: store wdata, set dirty.
  - Point the set's LRU bit at the other way; pulse cpu_done and hit; return to IDLE.
  - Hit latency: cpu_done is high in the 2nd cycle after the edge that accepted the request.
- COMPARE, miss:
  - Pulse miss (first lookup only).
  - Victim = invalid way (way0 first), else the LRU way.
  - Victim valid and dirty: pulse dirty, go to WRITEBACK. Otherwise go to ALLOCATE.
- WRITEBACK: mem_req=1, mem_we=1, mem_addr={victim tag, index}, mem_wdata = victim data. On mem_ack, clear the victim's dirty bit and go to ALLOCATE.
- ALLOCATE: mem_req=1, mem_we=0, mem_addr = latched address. On mem_ack, write the victim way (tag, data=mem_rdata, valid=1, dirty=0) and return to COMPARE. The replay then hits; a write replay updates data and sets dirty.
- Memory handshake:
  - mem_req, mem_we, mem_addr and mem_wdata stay stable until mem_ack is sampled high; mem_req deasserts on the next edge.
  - mem_ack already high in the first mem_req cycle completes a one-cycle transfer.
  - mem_ack while mem_req=0 is ignored.
- cpu_rdata holds its last value when cpu_done=0. Writes leave cpu_rdata unchanged.
- hit and miss are never both high in the same cycle.

Optional Feature:
- Macro CACHE_STATS_EN.
- Defined: adds ports hit_count (out, 16) and miss_count (out, 16). Each increments on its pulse and saturates at 0xFFFF; both reset to 0.
- Undefined: ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package cache_pkg:
  - state enum {IDLE, COMPARE, WRITEBACK, ALLOCATE};
  - localparams for index/tag widths derived from SETS and AW;
  - way-entry struct {valid, dirty, tag, data}.
- Sub-module cache_set_array: per-set two-way storage plus LRU bit, with a tag-compare and victim-select read port and a single write port.
- The FSM and memory handshake stay in cache_controller.

Test Plan (SETS=4):
- Reset, then read 0x14; memory acks after 3 cycles with 0xA5 -> miss pulse, dirty=0, mem read at 0x14, cpu_done with rdata 0xA5. Re-read 0x14 -> hit, done 2 cycles after accept, no mem_req.
- Write 0x14 ← 0x3C (hit), read 0x04 (miss, fills way1), read 0x24 -> victim way0 (LRU, dirty): dirty pulse, mem write addr 0x14 data 0x3C, then mem read 0x24.
- Write miss to 0x31 data 0x77, then evict it via 0x01 and 0x11 -> writeback of 0x77 to 0x31 observed.
- mem_ack held high continuously -> every mem_req lasts exactly 1 cycle; results match the delayed-ack run.
- Assert rst while in WRITEBACK -> mem_req falls without waiting for an edge, all outputs 0; a subsequent read 0x14 misses.
- CACHE_STATS_EN defined: 3 hits and 2 misses -> hit_count=3, miss_count=2; forced 0xFFFF + 1 hit stays at 0xFFFF.
